// File: rtl/spi_master.sv
// Single-frame SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// SCLK runs at CLKFREQ/(2*HALF), where HALF = CLKFREQ/(2*SPIFREQ).
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLKFREQ = 16,
    parameter int SPIFREQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             st,
    input  logic [WIDTH-1:0] din,
    input  logic             miso,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for st; cs_n high, sclk low
    // LEAD  | cs_n low, sclk low for HALF clks (CS setup)
    // SHIFT | WIDTH bits, each HALF clks sclk high then HALF clks sclk low
    // DONE  | one clk: done pulse, dout updated, cs_n released
    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} state_t;

    localparam int HALF = CLKFREQ / (2 * SPIFREQ);
    localparam int CW   = $clog2(HALF) + 1;
    localparam int BW   = $clog2(WIDTH) + 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bitc, bitc_n;
    logic [WIDTH-1:0] tx, tx_n;
    logic [WIDTH-1:0] rx, rx_n;
    logic [WIDTH-1:0] dout_n;
    logic             sclk_n, mosi_n, cs_n_n, busy_n, done_n;

    logic [WIDTH:0]   rx_ext;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] tx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            bitc  <= '0;
            tx    <= '0;
            rx    <= '0;
            dout  <= '0;
            sclk  <= 1'b0;
            mosi  <= 1'b0;
            cs_n  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bitc  <= bitc_n;
            tx    <= tx_n;
            rx    <= rx_n;
            dout  <= dout_n;
            sclk  <= sclk_n;
            mosi  <= mosi_n;
            cs_n  <= cs_n_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Outputs are registered, so transitions below take effect together with the state change.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitc_n  = bitc;
        tx_n    = tx;
        rx_n    = rx;
        dout_n  = dout;
        sclk_n  = sclk;
        mosi_n  = mosi;
        cs_n_n  = cs_n;
        busy_n  = busy;
        done_n  = 1'b0;

        rx_ext  = {rx, miso};
        rx_sh   = rx_ext[WIDTH-1:0];
        tx_sh   = tx << 1;

        unique case (state)
            IDLE: begin
                if (st) begin
                    tx_n    = din;
                    rx_n    = '0;
                    mosi_n  = din[WIDTH-1];
                    cs_n_n  = 1'b0;
                    busy_n  = 1'b1;
                    cnt_n   = CNT_LOAD;
                    bitc_n  = '0;
                    state_n = LEAD;
                end
            end
            LEAD: begin
                if (cnt == '0) begin
                    sclk_n  = 1'b1;
                    rx_n    = rx_sh;
                    cnt_n   = CNT_LOAD;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (sclk) begin
                    // After the last bit the shifted-out word is all zeros, so mosi returns to 0.
                    sclk_n = 1'b0;
                    tx_n   = tx_sh;
                    mosi_n = tx_sh[WIDTH-1];
                    cnt_n  = CNT_LOAD;
                end else if (bitc == BIT_LAST) begin
                    dout_n  = rx;
                    done_n  = 1'b1;
                    cs_n_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = DONE;
                end else begin
                    bitc_n = bitc + 1'b1;
                    sclk_n = 1'b1;
                    rx_n   = rx_sh;
                    cnt_n  = CNT_LOAD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master (WIDTH=13, HALF=4): expected frames are queued at
// start, a negedge monitor pops and checks them on every done pulse.
module tb_spi_master;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st = 1'b0;
    logic [W-1:0] din = '0;
    logic         miso;
    logic         sclk, mosi, cs_n, busy, done;
    logic [W-1:0] dout;

    // 0: miso tied 0, 1: miso tied 1, 2: loopback from mosi
    int miso_mode = 2;
    assign miso = (miso_mode == 2) ? mosi : (miso_mode == 1);

    spi_master #(.WIDTH(W), .CLKFREQ(16), .SPIFREQ(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .st   (st),
        .din  (din),
        .miso (miso),
        .sclk (sclk),
        .mosi (mosi),
        .cs_n (cs_n),
        .dout (dout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dout;
        logic [W-1:0] mosi_bits;
        int           cs_len;
        int           rises;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        int           cs_cnt;
        int           rises;
        logic [W-1:0] mcap;
        logic         sclk_q;
        logic         mosi_q;
        exp_t         e;
        cs_cnt = 0; rises = 0; mcap = '0; sclk_q = 1'b0; mosi_q = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cs_cnt = 0; rises = 0; mcap = '0; sclk_q = 1'b0; mosi_q = 1'b0;
            end else begin
                if (!cs_n) cs_cnt++;
                if (sclk && sclk_q && (mosi != mosi_q)) begin
                    miscompares++;
                    $display("FAIL mosi_stable: mosi moved to %0b while sclk high", mosi);
                end
                if (sclk && !sclk_q) begin
                    rises++;
                    mcap = {mcap[W-2:0], mosi};
                end
                sclk_q = sclk;
                mosi_q = mosi;
                if (done) begin
                    done_cnt++;
                    vectors++;
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_done: done with no frame pending, dout=%0h", dout);
                    end else begin
                        e = q.pop_front();
                        chk("dout", dout, e.dout);
                        chk("mosi_bits", mcap, e.mosi_bits);
                        chk("cs_low_clks", cs_cnt, e.cs_len);
                        chk("sclk_rises", rises, e.rises);
                        chk("busy_at_done", busy, 0);
                        chk("cs_n_at_done", cs_n, 1);
                    end
                    cs_cnt = 0; rises = 0; mcap = '0;
                end
            end
        end
    end

    task automatic start(input logic [W-1:0] v, input logic [W-1:0] exp_dout);
        exp_t e;
        e.dout = exp_dout; e.mosi_bits = v; e.cs_len = 108; e.rises = W;
        q.push_back(e);
        @(negedge clk);
        din = v;
        st  = 1'b1;
        @(negedge clk);
        st  = 1'b0;
        chk("busy_after_st", busy, 1);
        chk("cs_n_after_st", cs_n, 0);
    endtask

    task automatic wait_done(input string name);
        int base;
        base = done_cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_cnt != base) break;
        end
        chk({name, "_done_seen"}, done_cnt - base, 1);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_sclk"}, sclk, 0);
        chk({name, "_cs_n"}, cs_n, 1);
        chk({name, "_mosi"}, mosi, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_dout"}, dout, 0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pattern with loopback: mosi sequence and dout both equal din
        miso_mode = 2;
        start(13'b1001001001001, 13'b1001001001001);
        wait_done("loop_pattern");
        repeat (3) @(negedge clk);

        miso_mode = 1;
        start(13'h0F0F, 13'h1FFF);
        wait_done("miso_one");
        repeat (2) @(negedge clk);

        miso_mode = 0;
        start(13'h1555, 13'h0000);
        wait_done("miso_zero");
        repeat (2) @(negedge clk);

        // Second st mid-frame must be ignored
        miso_mode = 2;
        start(13'h0A5C, 13'h0A5C);
        repeat (40) @(negedge clk);
        din = 13'h1FFF;
        st  = 1'b1;
        @(negedge clk);
        st  = 1'b0;
        wait_done("midframe_st");
        base = done_cnt;
        repeat (150) @(negedge clk);
        chk("no_second_frame_done", done_cnt, base);
        chk("no_second_frame_busy", busy, 0);

        // Reset mid-SHIFT aborts without done, then a clean frame runs
        start(13'h1234, 13'h1234);
        repeat (30) @(negedge clk);
        chk("busy_before_abort", busy, 1);
        void'(q.pop_back());
        #2 rst_n = 1'b0;
        #1 check_idle("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        repeat (150) @(negedge clk);
        chk("no_done_after_abort", done_cnt, base);

        start(13'h1234, 13'h1234);
        wait_done("after_abort");
        repeat (5) @(negedge clk);

        chk("frames_total", done_cnt, 5);
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
